// File: rtl/wash_timer_pkg.sv
// wash_pkg: controller state codes, phase codes and per-program phase tables
package wash_pkg;
  localparam logic [2:0] stShutDown = 3'd0;
  localparam logic [2:0] stBegin    = 3'd1;
  localparam logic [2:0] stSet      = 3'd2;
  localparam logic [2:0] stRun      = 3'd3;
  localparam logic [2:0] stError    = 3'd4;
  localparam logic [2:0] stPause    = 3'd5;
  localparam logic [2:0] stFinish   = 3'd6;
  localparam logic [2:0] phFill      = 3'd1;
  localparam logic [2:0] phWash      = 3'd2;
  localparam logic [2:0] phSpin      = 3'd3;
  localparam logic [2:0] phFill2     = 3'd4;
  localparam logic [2:0] phRinse     = 3'd5;
  localparam logic [2:0] phDrain     = 3'd6;
  localparam logic [2:0] phFinalSpin = 3'd7;
  // Tables are packed index 0 in the low bits; the zero entries mark the end of a program.
  localparam logic [23:0] stdCodes   = {3'd0, phFinalSpin, phDrain, phRinse, phFill2, phSpin, phWash, phFill};
  localparam logic [23:0] quickCodes = {12'd0, phFinalSpin, phDrain, phWash, phFill};
  localparam logic [23:0] rinseCodes = {12'd0, phFinalSpin, phDrain, phRinse, phFill2};
  localparam logic [23:0] stdDurs    = {3'd0, 3'd5, 3'd2, 3'd4, 3'd2, 3'd3, 3'd6, 3'd2};
  localparam logic [23:0] quickDurs  = {12'd0, 3'd2, 3'd1, 3'd3, 3'd1};
  localparam logic [23:0] rinseDurs  = {12'd0, 3'd5, 3'd2, 3'd4, 3'd2};
  localparam logic [5:0] stdTotal   = 6'd24;
  localparam logic [5:0] quickTotal = 6'd7;
  localparam logic [5:0] rinseTotal = 6'd13;

  function automatic logic [2:0] phaseCode(input logic [1:0] m, input logic [2:0] i);
    logic [23:0] t;
    t = m == 2'd0 ? stdCodes : m == 2'd1 ? quickCodes : m == 2'd2 ? rinseCodes : 24'd0;
    return t[3*i +: 3];
  endfunction

  function automatic logic [2:0] phaseDur(input logic [1:0] m, input logic [2:0] i);
    logic [23:0] t;
    t = m == 2'd0 ? stdDurs : m == 2'd1 ? quickDurs : m == 2'd2 ? rinseDurs : 24'd0;
    return t[3*i +: 3];
  endfunction

  function automatic logic [5:0] progTotal(input logic [1:0] m);
    return m == 2'd0 ? stdTotal : m == 2'd1 ? quickTotal : m == 2'd2 ? rinseTotal : 6'd0;
  endfunction
endpackage

// File: rtl/wash_timer_if.sv
// wash_timer_if: controller-state input and timing/progress outputs of the wash timer
interface wash_timer_if;
  logic [2:0] state;
  logic modeBtn;
  logic [2:0] initTime;
  logic [2:0] finishTime;
  logic [2:0] shinning;
  logic hadFinish;
  logic [1:0] mode;
  logic [5:0] remainTime;
  modport master(output state, modeBtn, input initTime, finishTime, shinning, hadFinish, mode, remainTime);
  modport slave(input state, modeBtn, output initTime, finishTime, shinning, hadFinish, mode, remainTime);
endinterface

// File: rtl/wash_timer_tick_gen.sv
// tick_gen: one-cycle tick every TICK_DIV clocks, restartable by clr
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic cp,
  input logic rst,
  input logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge cp) cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wash_timer.sv
// wash_timer: program selection, phase sequencing and second countdowns for the washer
module wash_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int INIT_SEC = 3,
  parameter int FINISH_SEC = 5
) (
  input logic cp,
  input logic rst,
  wash_timer_if.slave bus
);
  logic tick, btnQ, btnEdge, hadFinish;
  logic [1:0] mode, nextMode;
  logic [2:0] initTime, finishTime, shinning, phaseIdx, phaseCnt, nxtIdx, nxtCode;
  logic [5:0] remainTime;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .cp(cp),
    .rst(rst),
    .clr(bus.state == stShutDown || bus.state == stSet),
    .tick(tick)
  );

  always_comb begin
    nextMode = (bus.state == stSet && btnEdge) ? (mode == 2'd2 ? 2'd0 : mode + 2'd1) : mode;
    nxtIdx = phaseIdx + 3'd1;
    nxtCode = phaseCode(mode, nxtIdx);
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      btnQ <= 1'b0;
      btnEdge <= 1'b0;
      initTime <= 3'(INIT_SEC);
      finishTime <= 3'(FINISH_SEC);
      hadFinish <= 1'b0;
      shinning <= '0;
      mode <= '0;
      phaseIdx <= '0;
      phaseCnt <= '0;
      remainTime <= '0;
    end else begin
      btnQ <= bus.modeBtn;
      btnEdge <= bus.modeBtn & ~btnQ;
      case (bus.state)
        stShutDown: begin
          initTime <= 3'(INIT_SEC);
          finishTime <= 3'(FINISH_SEC);
          hadFinish <= 1'b0;
          shinning <= '0;
          mode <= '0;
          phaseIdx <= '0;
          phaseCnt <= '0;
          remainTime <= '0;
        end
        stBegin: if (tick && initTime != 3'd0) initTime <= initTime - 3'd1;
        stSet: begin
          mode <= nextMode;
          phaseIdx <= '0;
          shinning <= phaseCode(nextMode, 3'd0);
          phaseCnt <= phaseDur(nextMode, 3'd0);
          remainTime <= progTotal(nextMode);
        end
        // A zero phase counter means nothing is loaded or the program already ended.
        stRun: if (tick && phaseCnt != 3'd0) begin
          remainTime <= nxtCode == 3'd0 && phaseCnt == 3'd1 ? 6'd0 : remainTime - 6'd1;
          if (phaseCnt != 3'd1) phaseCnt <= phaseCnt - 3'd1;
          else if (nxtCode == 3'd0) begin
            shinning <= '0;
            hadFinish <= 1'b1;
            phaseCnt <= '0;
          end else begin
            phaseIdx <= nxtIdx;
            shinning <= nxtCode;
            phaseCnt <= phaseDur(mode, nxtIdx);
          end
        end
        stFinish: if (tick && finishTime != 3'd0) finishTime <= finishTime - 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.initTime = initTime;
  assign bus.finishTime = finishTime;
  assign bus.shinning = shinning;
  assign bus.hadFinish = hadFinish;
  assign bus.mode = mode;
  assign bus.remainTime = remainTime;
endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: directed plan plus random state walks against an elapsed-seconds model
module tb_wash_timer;
  localparam int TD = 4;
  localparam int INIT = 3;
  localparam int FIN = 5;
  logic cp = 1'b0;
  logic rst;
  wash_timer_if bus();
  wash_timer #(.TICK_DIV(TD), .INIT_SEC(INIT), .FINISH_SEC(FIN)) dut (.cp(cp), .rst(rst), .bus(bus));
  always #5 cp = ~cp;

  int nChecks = 0;
  int nErrors = 0;
  int progCodes[3][7] = '{'{1, 2, 3, 4, 5, 6, 7}, '{1, 2, 6, 7, 0, 0, 0}, '{4, 5, 6, 7, 0, 0, 0}};
  int progDurs[3][7] = '{'{2, 6, 3, 2, 4, 2, 5}, '{1, 3, 1, 2, 0, 0, 0}, '{2, 4, 2, 5, 0, 0, 0}};
  int mPre, mInit, mFin, mHad, mMode, mEl, mLoaded, b1, b2;

  task automatic check(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int total(input int m);
    int s = 0;
    for (int i = 0; i < 7; i++) s += progDurs[m][i];
    return s;
  endfunction

  // Phase in force after e whole seconds of running: first phase whose cumulative end lies beyond e.
  function automatic int phaseAt(input int m, input int e);
    int acc = 0;
    for (int i = 0; i < 7; i++) begin
      acc += progDurs[m][i];
      if (progCodes[m][i] != 0 && e < acc) return progCodes[m][i];
    end
    return 0;
  endfunction

  task automatic modelEdge();
    int st, tk, adv;
    if (rst) begin
      mPre = 0; b1 = 0; b2 = 0;
      mInit = INIT; mFin = FIN; mHad = 0; mMode = 0; mEl = 0; mLoaded = 0;
      return;
    end
    st = int'(bus.state);
    tk = (mPre == TD - 1) ? 1 : 0;
    adv = (st == 2 && b1 == 1 && b2 == 0) ? 1 : 0;
    b2 = b1;
    b1 = int'(bus.modeBtn);
    case (st)
      0: begin mInit = INIT; mFin = FIN; mHad = 0; mMode = 0; mEl = 0; mLoaded = 0; end
      1: if (tk == 1 && mInit > 0) mInit--;
      2: begin
        if (adv == 1) mMode = (mMode + 1) % 3;
        mEl = 0;
        mLoaded = 1;
      end
      3: if (tk == 1 && mLoaded == 1 && mEl < total(mMode)) begin
        mEl++;
        if (mEl == total(mMode)) mHad = 1;
      end
      6: if (tk == 1 && mFin > 0) mFin--;
      default: ;
    endcase
    mPre = (st == 0 || st == 2 || tk == 1) ? 0 : mPre + 1;
  endtask

  task automatic step();
    @(posedge cp);
    modelEdge();
    #1;
    check("initTime", int'(bus.initTime), mInit);
    check("finishTime", int'(bus.finishTime), mFin);
    check("hadFinish", int'(bus.hadFinish), mHad);
    check("mode", int'(bus.mode), mMode);
    check("shinning", int'(bus.shinning), mLoaded == 1 ? phaseAt(mMode, mEl) : 0);
    check("remainTime", int'(bus.remainTime), mLoaded == 1 ? total(mMode) - mEl : 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    bus.modeBtn = 1'b1;
    step();
    bus.modeBtn = 1'b0;
    steps(2);
  endtask

  initial begin
    int found;
    rst = 1'b1;
    bus.state = 3'd0;
    bus.modeBtn = 1'b0;
    steps(2);
    check("rstInit", int'(bus.initTime), 3);
    check("rstFinish", int'(bus.finishTime), 5);
    check("rstShin", int'(bus.shinning), 0);
    rst = 1'b0;
    bus.state = 3'd1;
    steps(12);
    check("beginInit", int'(bus.initTime), 0);
    check("beginHad", int'(bus.hadFinish), 0);
    bus.state = 3'd2;
    steps(3);
    pulse();
    check("setMode", int'(bus.mode), 1);
    check("setShin", int'(bus.shinning), 1);
    check("setRemain", int'(bus.remainTime), 7);
    bus.modeBtn = 1'b1;
    steps(10);
    bus.modeBtn = 1'b0;
    steps(2);
    check("holdOneAdv", int'(bus.mode), 2);
    pulse();
    pulse();
    check("quickMode", int'(bus.mode), 1);
    bus.state = 3'd3;
    steps(32);
    check("quickHad", int'(bus.hadFinish), 1);
    check("quickRemain", int'(bus.remainTime), 0);
    check("quickShin", int'(bus.shinning), 0);
    bus.state = 3'd0;
    step();
    bus.state = 3'd2;
    steps(2);
    bus.state = 3'd3;
    steps(20);
    check("runRemain", int'(bus.remainTime), 19);
    check("runShin", int'(bus.shinning), 2);
    bus.state = 3'd5;
    steps(20);
    check("pauseRemain", int'(bus.remainTime), 19);
    check("pauseShin", int'(bus.shinning), 2);
    bus.state = 3'd3;
    steps(76);
    check("stdHad", int'(bus.hadFinish), 1);
    bus.state = 3'd6;
    steps(24);
    check("finFinish", int'(bus.finishTime), 0);
    check("finHad", int'(bus.hadFinish), 1);
    bus.state = 3'd0;
    step();
    bus.state = 3'd2;
    step();
    bus.state = 3'd3;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (bus.shinning == 3'd5) found = 1;
    end
    check("reachRinse", found, 1);
    rst = 1'b1;
    step();
    check("midRstInit", int'(bus.initTime), 3);
    check("midRstShin", int'(bus.shinning), 0);
    check("midRstRemain", int'(bus.remainTime), 0);
    check("midRstMode", int'(bus.mode), 0);
    rst = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      int pick, len;
      pick = $urandom_range(0, 11);
      bus.state = pick < 8 ? 3'(pick) : (pick < 10 ? 3'd3 : 3'd2);
      len = bus.state == 3'd3 ? $urandom_range(10, 60) : $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        bus.modeBtn = $urandom_range(0, 3) == 0;
        rst = $urandom_range(0, 399) == 0;
        step();
      end
      rst = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/wash_timer.md
# wash_timer

Timing and program-sequencing stage for the washing-machine controller. Consumes the 3-bit controller state and produces the timing/progress signals the controller branches on:
- `initTime`: power-on countdown.
- `finishTime`: end-of-cycle countdown.
- `shinning`: current wash phase code.
- `hadFinish`: program complete.

Also holds the user-selected program and exposes the remaining run time for display.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `cp` cycles per one-second tick.
- `INIT_SEC`, default 3: power-on countdown length in seconds.
- `FINISH_SEC`, default 5: finish countdown length in seconds.

Ports:
- `cp`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `state`, in, 3: controller state code.
- `modeBtn`, in, 1: program select button, level, synchronous to `cp`.
- `initTime`, out, 3: power-on seconds remaining.
- `finishTime`, out, 3: finish-beep seconds remaining.
- `shinning`, out, 3: active phase code; 0 when idle.
- `hadFinish`, out, 1: program completed.
- `mode`, out, 2: selected program; 0 standard, 1 quick, 2 rinse-only.
- `remainTime`, out, 6: run seconds remaining in the program.

## Operation
- State codes:
  - 0 shutDown
  - 1 begin
  - 2 set
  - 3 run
  - 4 error
  - 5 pause
  - 6 finish
- Phase codes:
  - 1 fill
  - 2 wash
  - 3 spin
  - 4 fill2
  - 5 rinse
  - 6 drain
  - 7 final spin
- Codes 3 and 7 are the door-locked spin phases.
- Programs, as ordered phase:seconds lists:
  - Standard: 1:2, 2:6, 3:3, 4:2, 5:4, 6:2, 7:5, total 24.
  - Quick: 1:1, 2:3, 6:1, 7:2, total 7.
  - Rinse-only: 4:2, 5:4, 6:2, 7:5, total 13.
- shutDown (every cycle):
  - `initTime`=INIT_SEC, `finishTime`=FINISH_SEC, `hadFinish`=0, `shinning`=0, `mode`=0.
  - Internal phase index=0, phase counter=0, `remainTime`=0.
- begin: on each tick, `initTime` decrements, saturating at 0.
- set:
  - A rising edge of `modeBtn` (internal one-cycle edge detect) advances `mode` 0→1→2→0.
  - Every cycle in set loads the phase index with the first phase of `mode`.
  - `shinning` takes that first phase code.
  - The phase counter takes its duration; `remainTime` takes the program total.
- run, on each tick:
  - `remainTime` decrements and the phase counter decrements.
  - When the phase counter is 1 at the tick, advance to the next phase: load its code and duration.
  - If the expiring phase is the last one: `shinning`=0, `hadFinish`=1, `remainTime`=0.
- error, pause: all outputs and counters hold.
- finish:
  - On each tick, `finishTime` decrements, saturating at 0.
  - `hadFinish` stays 1 until shutDown.
- `modeBtn` is ignored outside set. Undefined codes (7) hold everything.

## Timing
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is a one-cycle pulse at count TICK_DIV-1.
  - Cleared to 0 on `rst` and whenever `state`=shutDown or `state`=set.
  - As a result, the first run second is a full TICK_DIV cycles.
- All outputs are registered and update on the `cp` edge where tick is high.
- `hadFinish` rises on the same edge the last phase expires. The controller reaches finish one cycle later.
- Mode-change latency: `mode` and `shinning` update one cycle after the `modeBtn` edge is registered, i.e. two cycles after the button rises.
- `rst` has priority over everything, including mid-run. It forces all outputs to their shutDown values, with `initTime`=INIT_SEC and `finishTime`=FINISH_SEC.
- Simultaneous tick and state change: the action is chosen by the `state` value sampled on that edge.

## Structure
- Package `wash_pkg`:
  - State code localparams.
  - Phase code localparams.
  - Per-program phase lists and durations as constant functions indexed by (`mode`, index).
  - Program totals.
- One sub-module `tick_gen`: the prescaler with parameter TICK_DIV, inputs `cp`/`rst`/`clr`, output `tick`.
- Phase table lookup is combinational inside `wash_timer`.

## Test plan
Use TICK_DIV=4 throughout.
- Reset then `state`=1 for 12 cycles:
  - `initTime` steps 3,2,1,0 at ticks, then holds 0.
  - `shinning`=0, `hadFinish`=0.
- `state`=2, pulse `modeBtn` once:
  - `mode`=1, `shinning`=1, `remainTime`=7.
  - Hold `modeBtn` high 10 cycles: only one advance.
- `mode`=1, `state`=3:
  - `shinning` sequence is 1 (1 tick), 2 (3), 6 (1), 7 (2).
  - `hadFinish`=1 at tick 7 with `remainTime`=0 and `shinning`=0.
- Standard program, run 5 ticks, `state`=5 for 20 cycles, then back to 3:
  - `remainTime` holds at 19 and `shinning` holds at 2 while paused.
  - Counting then resumes.
- `state`=6 for 24 cycles: `finishTime` 5→0 and holds; `hadFinish` stays 1.
- `rst`=1 during run at phase 5: next edge gives every output at its reset value; `mode`=0.
